// File: rtl/fpu_hp_cmd_sequencer.sv
// Command sequencer: assembles UART command frames into FPU issues and latches results/flags.
// Optional done-watchdog enabled by defining FPU_SEQ_WDOG_EN.
module fpu_hp_cmd_sequencer #(
  parameter logic [15:0] GAP_CYCLES   = 16'd4096,
  parameter logic [15:0] DONE_TIMEOUT = 16'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        fpu_start,
  output logic [4:0]  fpu_op,
  output logic [2:0]  fpu_rm,
  output logic [15:0] fpu_rs1,
  output logic [15:0] fpu_rs2,
  output logic [15:0] fpu_rs3,
  input  logic        fpu_done,
  input  logic [15:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic [15:0] result,
  output logic        result_valid,
  output logic [4:0]  flags_sticky,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX_A  = 3'd1,
    RX_B  = 3'd2,
    RX_C  = 3'd3,
    ISSUE = 3'd4,
    WAIT  = 3'd5
  } state_t;

  state_t      state, state_next;
  logic        hi;
  logic [15:0] gap_cnt;
  logic        is_clr, in_rx, gap_hit, overrun, op_done, wd_expire;

`ifdef FPU_SEQ_WDOG_EN
  logic [15:0] wd_cnt;
  // fpu_done in the timeout cycle still completes normally
  assign wd_expire = (state == WAIT) && !fpu_done && (wd_cnt == DONE_TIMEOUT - 16'd1);
`else
  logic unused_cfg;
  assign unused_cfg = ^DONE_TIMEOUT;
  assign wd_expire  = 1'b0;
`endif

  always_comb begin
    state_next = state;
    is_clr     = (rx_byte[4:0] == 5'h1F);
    in_rx      = (state == RX_A) || (state == RX_B) || (state == RX_C);
    gap_hit    = in_rx && !rx_valid && (gap_cnt == GAP_CYCLES - 16'd1);
    overrun    = rx_valid && ((state == ISSUE) || (state == WAIT));
    op_done    = (state == WAIT) && fpu_done;
    case (state)
      IDLE:  if (rx_valid && !is_clr) state_next = RX_A;
      RX_A: begin
        if (rx_valid && hi) state_next = RX_B;
        else if (gap_hit)   state_next = IDLE;
      end
      RX_B: begin
        if (rx_valid && hi) state_next = fpu_op[4] ? RX_C : ISSUE;
        else if (gap_hit)   state_next = IDLE;
      end
      RX_C: begin
        if (rx_valid && hi) state_next = ISSUE;
        else if (gap_hit)   state_next = IDLE;
      end
      ISSUE: state_next = WAIT;
      WAIT:  if (fpu_done || wd_expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hi           <= 1'b0;
      gap_cnt      <= 16'd0;
      fpu_start    <= 1'b0;
      fpu_op       <= 5'd0;
      fpu_rm       <= 3'd0;
      fpu_rs1      <= 16'h0000;
      fpu_rs2      <= 16'h0000;
      fpu_rs3      <= 16'h0000;
      result       <= 16'h0000;
      result_valid <= 1'b0;
      flags_sticky <= 5'd0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_next;
      fpu_start    <= (state_next == ISSUE);
      busy         <= (state_next != IDLE);
      result_valid <= op_done;

      if (op_done) begin
        result       <= fpu_result;
        flags_sticky <= flags_sticky | fpu_flags;
      end

      if ((state == IDLE) && rx_valid && is_clr) begin
        flags_sticky <= 5'd0;
        err          <= 1'b0;
      end else if (gap_hit || overrun || wd_expire) begin
        err <= 1'b1;
      end

      // byte0 opens a frame; each operand byte flips the lo/hi lane
      if ((state == IDLE) && rx_valid && !is_clr) begin
        fpu_op  <= rx_byte[4:0];
        fpu_rm  <= rx_byte[7:5];
        fpu_rs3 <= 16'h0000;
        hi      <= 1'b0;
        gap_cnt <= 16'd0;
      end else if (in_rx) begin
        if (rx_valid) begin
          gap_cnt <= 16'd0;
          hi      <= ~hi;
          case (state)
            RX_A:    if (hi) fpu_rs1[15:8] <= rx_byte; else fpu_rs1[7:0] <= rx_byte;
            RX_B:    if (hi) fpu_rs2[15:8] <= rx_byte; else fpu_rs2[7:0] <= rx_byte;
            RX_C:    if (hi) fpu_rs3[15:8] <= rx_byte; else fpu_rs3[7:0] <= rx_byte;
            default: hi <= 1'b0;
          endcase
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
      end
    end
  end

`ifdef FPU_SEQ_WDOG_EN
  always_ff @(posedge clk) begin
    if (rst)                  wd_cnt <= 16'd0;
    else if (state == ISSUE)  wd_cnt <= 16'd1;
    else if (state == WAIT)   wd_cnt <= wd_cnt + 16'd1;
    else                      wd_cnt <= 16'd0;
  end
`endif

endmodule
